crc32_execute: RTL and testbench

CRC32_EXECUTE -- requirements
Module: crc32_execute

---
 rtl/crc32_execute.sv | 127 ++++++++++++
 tb/tb_crc32_execute.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/crc32_execute.sv
// CRC-32 execute unit: folds one data byte into the running CRC over
// eight single-bit shift cycles, or reloads the CRC register in one cycle.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for a crc32 instruction from the execute stage
// SHIFT  | folding data_reg into crc_reg one bit per cycle (8 cycles)
// DONE   | one-cycle completion pulse, result visible on crc_out
module crc32_execute #(
  parameter logic [31:0] POLY = 32'hEDB88320,
  parameter logic [31:0] INIT = 32'hFFFFFFFF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic        op_reset,
  input  logic        op_new_byte,
  input  logic [7:0]  byte_in,
  input  logic        kill,
  output logic        busy,
  output logic        done,
  output logic [31:0] crc_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] crc_reg;
  logic [31:0] snapshot;
  logic [7:0]  data_reg;
  logic [2:0]  bit_cnt;
  logic        fb;

  // A killed instruction is never accepted, whatever its op bits say.
  logic        accept;
  assign accept = start & ~kill;

  // State register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; reset op takes priority over new_byte.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (op_reset) begin
            state_nxt = ST_DONE;
          end else if (op_new_byte) begin
            state_nxt = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (kill) begin
          state_nxt = ST_IDLE;
        end else if (bit_cnt == 3'd7) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs: stall while shifting or when a byte op is being accepted.
  always_comb begin
    done    = (state == ST_DONE);
    busy    = (state == ST_SHIFT) |
              ((state == ST_IDLE) & start & ~op_reset & op_new_byte);
    crc_out = ~crc_reg;
  end

  assign fb = crc_reg[0] ^ data_reg[0];

  // Datapath: CRC reload, byte capture, bit-serial LFSR, kill rollback.
  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_reg  <= INIT;
      snapshot <= INIT;
      data_reg <= 8'h00;
      bit_cnt  <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (op_reset) begin
              crc_reg <= INIT;
            end else if (op_new_byte) begin
              snapshot <= crc_reg;
              data_reg <= byte_in;
              bit_cnt  <= 3'd0;
            end
          end
        end
        ST_SHIFT: begin
          if (kill) begin
            // Flushed mid-byte: restore the CRC as it was before this op.
            crc_reg <= snapshot;
          end else begin
            crc_reg  <= (crc_reg >> 1) ^ (fb ? POLY : 32'h0);
            data_reg <= data_reg >> 1;
            bit_cnt  <= bit_cnt + 3'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_execute.sv
// Self-checking bench for crc32_execute with a table-driven CRC-32 model.
module tb_crc32_execute;

  localparam logic [31:0] POLY = 32'hEDB88320;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic        op_reset;
  logic        op_new_byte;
  logic [7:0]  byte_in;
  logic        kill;
  logic        busy;
  logic        done;
  logic [31:0] crc_out;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          done_cnt = 0;
  logic [31:0] model_crc;
  logic [31:0] crc_tab [256];

  crc32_execute #(.POLY(POLY), .INIT(INIT)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .op_reset    (op_reset),
    .op_new_byte (op_new_byte),
    .byte_in     (byte_in),
    .kill        (kill),
    .busy        (busy),
    .done        (done),
    .crc_out     (crc_out)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] crc_update(input logic [31:0] crc, input logic [7:0] b);
    logic [7:0] idx;
    idx = crc[7:0] ^ b;
    return (crc >> 8) ^ crc_tab[idx];
  endfunction

  task automatic build_table();
    logic [31:0] c;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      crc_tab[i] = c;
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; op_reset = 1'b0; op_new_byte = 1'b0; kill = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge CLK);
    RST = 1'b1; idle_inputs();
    @(negedge CLK);
    #1 check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_crc", crc_out, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    #1 check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_crc", crc_out, 32'h0);
    model_crc = INIT;
  endtask

  task automatic reset_op(input bit nb);
    @(negedge CLK);
    start = 1'b1; op_reset = 1'b1; op_new_byte = nb; kill = 1'b0; byte_in = 8'($urandom);
    #1 check("rop_busy_n", busy, 0);
    check("rop_done_n", done, 0);
    @(negedge CLK);
    idle_inputs();
    model_crc = INIT;
    #1 check("rop_done", done, 1);
    check("rop_busy", busy, 0);
    check("rop_crc", crc_out, ~model_crc);
  endtask

  // kill_at: SHIFT cycle (1..8) to assert kill in, 0 for none.
  task automatic byte_op(input logic [7:0] b, input int kill_at, input bit noise, input bit kill_done);
    @(negedge CLK);
    start = 1'b1; op_reset = 1'b0; op_new_byte = 1'b1; byte_in = b; kill = 1'b0;
    #1 check("bop_busy_acc", busy, 1);
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK);
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        op_reset = 1'($urandom_range(0, 1));
        op_new_byte = 1'($urandom_range(0, 1));
        byte_in = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      kill = (k == kill_at);
      #1 check("bop_busy_shift", busy, 1);
      check("bop_done_shift", done, 0);
      if (k == kill_at) begin
        @(negedge CLK);
        idle_inputs();
        #1 check("kill_done", done, 0);
        check("kill_busy", busy, 0);
        check("kill_crc", crc_out, ~model_crc);
        return;
      end
    end
    @(negedge CLK);
    start = 1'b0; op_reset = 1'b0; op_new_byte = 1'b0; kill = kill_done;
    model_crc = crc_update(model_crc, b);
    #1 check("bop_done", done, 1);
    check("bop_busy_done", busy, 0);
    check("bop_crc", crc_out, ~model_crc);
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic noop_start();
    @(negedge CLK);
    start = 1'b1; op_reset = 1'b0; op_new_byte = 1'b0; kill = 1'b0; byte_in = 8'($urandom);
    #1 check("noop_busy_n", busy, 0);
    @(negedge CLK);
    idle_inputs();
    #1 check("noop_done", done, 0);
    check("noop_busy", busy, 0);
    check("noop_crc", crc_out, ~model_crc);
  endtask

  task automatic kill_idle(input bit rst_op);
    @(negedge CLK);
    start = 1'b1; op_reset = rst_op; op_new_byte = 1'b1; kill = 1'b1; byte_in = 8'($urandom);
    @(negedge CLK);
    idle_inputs();
    #1 check("kidle_done", done, 0);
    check("kidle_busy", busy, 0);
    check("kidle_crc", crc_out, ~model_crc);
  endtask

  task automatic rst_mid_shift();
    bit saw_done;
    saw_done = 1'b0;
    @(negedge CLK);
    start = 1'b1; op_reset = 1'b0; op_new_byte = 1'b1; byte_in = 8'($urandom); kill = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      start = 1'b1; op_reset = 1'b0; op_new_byte = 1'b1; byte_in = 8'($urandom);
      RST = (k == 3);
      #1 check("rms_busy_shift", busy, 1);
    end
    @(negedge CLK);
    RST = 1'b0; idle_inputs();
    model_crc = INIT;
    #1 check("rms_busy", busy, 0);
    check("rms_done", done, 0);
    check("rms_crc", crc_out, 32'h0);
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      #1 if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    check("rms_quiet", 32'(saw_done), 0);
  endtask

  initial begin
    RST = 1'b1; byte_in = 8'h00;
    idle_inputs();
    build_table();
    model_crc = INIT;

    apply_reset();

    reset_op(0);
    byte_op(8'h61, 0, 0, 0);
    check("crc_a", crc_out, 32'hE8B7BE43);

    reset_op(0);
    done_cnt = 0;
    for (int i = 0; i < 9; i++) byte_op(8'h31 + 8'(i), 0, 1, 0);
    check("crc_123456789", crc_out, 32'hCBF43926);
    check("done_pulses_9", 32'(done_cnt), 9);

    reset_op(0);
    byte_op(8'h00, 0, 0, 0);
    check("crc_00", crc_out, 32'hD202EF8D);
    byte_op(8'h61, 4, 0, 0);
    check("crc_after_kill", crc_out, 32'hD202EF8D);
    byte_op(8'h61, 0, 0, 0);

    byte_op(8'hA5, 0, 0, 0);
    reset_op(1);
    check("crc_both_bits", crc_out, 32'h0);

    byte_op(8'h3C, 0, 0, 1);
    kill_idle(0);
    kill_idle(1);
    noop_start();
    byte_op(8'hFF, 8, 0, 0);

    byte_op(8'h12, 0, 0, 0);
    rst_mid_shift();

    for (int n = 0; n < 80; n++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5)       byte_op(8'($urandom), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else if (r == 5) byte_op(8'($urandom), int'($urandom_range(1, 8)), 1'($urandom_range(0, 1)), 0);
      else if (r == 6) reset_op(1'($urandom_range(0, 1)));
      else if (r == 7) noop_start();
      else if (r == 8) kill_idle(1'($urandom_range(0, 1)));
      else begin
        @(negedge CLK);
        idle_inputs();
        #1 check("idle_crc", crc_out, ~model_crc);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
